// File: rtl/range_seq_pkg.sv
// range_seq_pkg: shared state type and default sizes for the range window sequencer
package range_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, RESULT, HOLD} state_t;
    localparam int DEF_WIDTH  = 12;
    localparam int DEF_CNT_W  = 8;
    localparam int MIN_WINDOW = 2;
endpackage

// File: rtl/range_window_sequencer_window_counter.sv
// window_counter: loadable up-counter that flags the final step before its limit
module window_counter
    import range_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
)(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] init_i,
    input  logic [CNT_W-1:0] limit_i,
    input  logic             inc_i,
    output logic             last_o
);
    logic [CNT_W-1:0] count_q, count_d, limit_q, limit_d;
    // reload on load, step on inc, otherwise hold
    always_comb begin
        count_d = load_i ? init_i : (inc_i ? count_q + CNT_W'(1) : count_q);
        limit_d = load_i ? limit_i : limit_q;
    end
    // counter and limit registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
            limit_q <= '0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end
    assign last_o = count_q == limit_q - CNT_W'(1);
endmodule

// File: rtl/range_window_sequencer.sv
// range_window_sequencer: frames samples into windows for the range finder; RANGE_SEQ_TIMEOUT_EN adds HOLD timeout
module range_window_sequencer
  import range_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = 64
)(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] window_len,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_go,
  output logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic [WIDTH-1:0] range_out,
  output logic             range_valid,
  input  logic             range_ready,
  output logic             busy,
  output logic             overrun,
  output logic             rf_err_seen
`ifdef RANGE_SEQ_TIMEOUT_EN
  ,
  output logic             timeout_drop
`endif
);
  state_t           state_q;
  logic [WIDTH-1:0] rf_data_q, range_out_q;
  logic             rf_go_q, rf_finish_q, range_valid_q, overrun_q, rf_err_seen_q;
  logic [CNT_W-1:0] win_len;
  logic             start, win_last;
  assign win_len = (window_len < CNT_W'(MIN_WINDOW)) ? CNT_W'(MIN_WINDOW) : window_len;
  assign start   = state_q == IDLE && enable && sample_valid;
  window_counter #(.CNT_W(CNT_W)) u_win (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (start),
    .init_i  (CNT_W'(1)),
    .limit_i (win_len),
    .inc_i   (state_q == RUN && sample_valid),
    .last_o  (win_last)
  );
`ifdef RANGE_SEQ_TIMEOUT_EN
  logic timeout_drop_q, to_last;
  window_counter #(.CNT_W(CNT_W)) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (state_q == RESULT),
    .init_i  ('0),
    .limit_i (CNT_W'(TIMEOUT)),
    .inc_i   (state_q == HOLD),
    .last_o  (to_last)
  );
  assign timeout_drop = timeout_drop_q;
`endif
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rf_data_q     <= '0;
      rf_go_q       <= 1'b0;
      rf_finish_q   <= 1'b0;
      range_out_q   <= '0;
      range_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      rf_err_seen_q <= 1'b0;
`ifdef RANGE_SEQ_TIMEOUT_EN
      timeout_drop_q <= 1'b0;
`endif
    end else begin
      rf_go_q     <= 1'b0;
      rf_finish_q <= 1'b0;
      if (rf_error) rf_err_seen_q <= 1'b1;
      case (state_q)
        IDLE: if (start) begin
          rf_data_q <= sample_in;
          rf_go_q   <= 1'b1;
          state_q   <= RUN;
        end
        RUN: if (sample_valid) begin
          rf_data_q <= sample_in;
          if (win_last) begin
            rf_finish_q <= 1'b1;
            state_q     <= RESULT;
          end
        end
        RESULT: begin
          if (sample_valid) overrun_q <= 1'b1;
          if (!rf_finish_q) begin
            range_out_q   <= rf_range;
            range_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (sample_valid) overrun_q <= 1'b1;
          if (range_ready) begin
            range_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
`ifdef RANGE_SEQ_TIMEOUT_EN
          else if (to_last) begin
            range_valid_q  <= 1'b0;
            timeout_drop_q <= 1'b1;
            state_q        <= IDLE;
          end
`endif
        end
      endcase
    end
  end
  assign rf_data     = rf_data_q;
  assign rf_go       = rf_go_q;
  assign rf_finish   = rf_finish_q;
  assign range_out   = range_out_q;
  assign range_valid = range_valid_q;
  assign busy        = state_q != IDLE;
  assign overrun     = overrun_q;
  assign rf_err_seen = rf_err_seen_q;
endmodule

// File: doc/range_window_sequencer.md
Name: range_window_sequencer

Overview:
- Controller that sequences the 12-bit range-finder datapath: frames a stream of incoming samples into windows of programmable length.
- Drives the finder's go/finish strobes and data, then captures the resulting range.
- Presents the range on a valid/ready output handshake.
- Sits between the chip's io_in sample source and the range-finder instance, replacing the constant go=1/finish=0 tie-off.

Parameters:
- WIDTH, 12, sample and range width
- CNT_W, 8, width of window_len and the internal sample counter
- TIMEOUT, 64, HOLD timeout in cycles (used only with the optional feature)

Ports:
- clock  input  1  system clock; all logic is on its rising edge
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clock
- enable  input  1  permits a new window to start; sampled only in IDLE
- window_len  input  CNT_W  samples per window; latched at window start; values 0 and 1 are treated as 2
- sample_in  input  WIDTH  sample data
- sample_valid  input  1  sample_in is valid this cycle
- rf_data  output  WIDTH  data to the range finder
- rf_go  output  1  one-cycle strobe accompanying the first sample of a window
- rf_finish  output  1  one-cycle strobe accompanying the last sample of a window
- rf_range  input  WIDTH  finder result; valid the cycle after rf_finish
- rf_error  input  1  finder debug_error
- range_out  output  WIDTH  captured range; stable while range_valid=1
- range_valid  output  1  result available
- range_ready  input  1  consumer accepts the result
- busy  output  1  high in every state except IDLE
- overrun  output  1  sticky; a sample arrived while in RESULT or HOLD (sample dropped)
- rf_err_seen  output  1  sticky; rf_error was observed high

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; all outputs are 0; counter is 0. Reset has priority over every other event and aborts any window in progress.
- States: IDLE, RUN, RESULT, HOLD.
- IDLE, on enable & sample_valid:
  - rf_data<=sample_in, rf_go<=1.
  - Latch L=max(window_len,2); count<=1.
  - Go to RUN.
  - Otherwise stay in IDLE; samples are ignored and overrun is not set.
- RUN:
  - rf_go and rf_finish are one-cycle registered pulses, aligned with the registered rf_data.
  - sample_valid=1: rf_data<=sample_in and count increments.
  - If count==L-1 (this sample is the last of the window): rf_finish<=1 and go to RESULT.
  - sample_valid=0: rf_data holds its previous value (a repeated value does not change min/max) and both strobes are 0.
  - enable is not re-checked, so a window always completes once started.
- RESULT (the cycle after rf_finish is high): range_out<=rf_range, range_valid<=1, go to HOLD.
- HOLD:
  - range_out and range_valid are held until range_valid & range_ready.
  - On that handshake: range_valid<=0 and go to IDLE. The next window starts on the next accepted sample, at the earliest one cycle later.
- Latency: from the edge accepting the last sample, rf_finish is high in cycle +1 and range_valid is high from cycle +3.
- overrun: set when sample_valid=1 in RESULT or HOLD; cleared only by reset.
- rf_err_seen: set when rf_error=1 in any state; cleared only by reset.
- Simultaneous sample_valid and handshake in HOLD: the sample is dropped and overrun is set.
- Counter arithmetic is unsigned CNT_W bits. L is at most 2^CNT_W-1, so the counter never wraps.

Optional Feature:
- Macro RANGE_SEQ_TIMEOUT_EN.
- Defined: a counter runs in HOLD. After TIMEOUT consecutive HOLD cycles without ready, the result is discarded: range_valid<=0, go to IDLE, and an extra output timeout_drop (1 bit, sticky, reset 0) is set.
- Undefined: HOLD waits indefinitely, and timeout_drop and its counter do not exist.

Decomposition:
- Package range_seq_pkg holds:
  - state enum typedef (IDLE, RUN, RESULT, HOLD)
  - default WIDTH/CNT_W constants
  - MIN_WINDOW=2 constant
- Sub-module window_counter: loads L, counts accepted samples, flags the last sample. It is reused by the timeout counter when the optional feature is enabled.

Test Plan:
- L=4, enable=1, back-to-back samples 5,100,37,80 with the real range finder: rf_go with 5, rf_finish with 80, range_out=95, range_valid 3 cycles after the last sample; ready=1 returns to IDLE.
- L=3, samples 10,(gap 2 cycles),200,(gap),50: rf_data holds 10 during the gaps, no strobes during the gaps, range_out=190.
- Result pending with ready=0 for 10 cycles and a sample in HOLD: range_out stable, overrun=1, that sample absent from the next window.
- window_len=0 and window_len=1: both windows close after 2 samples (rf_finish on the second).
- reset_n=0 mid-RUN after 2 of 5 samples: all outputs 0 next cycle, state IDLE; the next sample raises a fresh rf_go.
- With RANGE_SEQ_TIMEOUT_EN, TIMEOUT=8 and ready held 0: range_valid drops after 8 HOLD cycles, timeout_drop=1, busy=0.
